// File: rtl/boot_verifier_pkg.sv
// rtl/boot_verifier_pkg.sv - state encoding and checksum width for the boot read-back checker
package boot_verifier_pkg;

  localparam int BV_SUM_W = 16;

  typedef enum logic [1:0] {
    BV_IDLE   = 2'd0,
    BV_RUN    = 2'd1,
    BV_DRAIN  = 2'd2,
    BV_FINISH = 2'd3
  } bv_state_t;

endpackage

// File: rtl/boot_verifier_checksum16.sv
// rtl/boot_verifier_checksum16.sv - 16-bit byte-sum accumulator, clear has priority over enable
module checksum16
  import boot_verifier_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                CLR,
  input  logic                EN,
  input  logic [7:0]          DATA,
  output logic [BV_SUM_W-1:0] SUM
);

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      SUM <= '0;
    end else if (EN) begin
      SUM <= SUM + {{(BV_SUM_W-8){1'b0}}, DATA};
    end
  end

endmodule

// File: rtl/boot_verifier.sv
// rtl/boot_verifier.sv - walks an SRAM region, checksums every byte and compares with the expected sum
module boot_verifier
  import boot_verifier_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int READ_LAT = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [ADDR_W-1:0]   BASE,
  input  logic [ADDR_W-1:0]   LENGTH,
  input  logic [BV_SUM_W-1:0] EXPECTED,
  output logic [ADDR_W-1:0]   ADDR,
  output logic                N_OE,
  input  logic [7:0]          DATA,
  output logic                BUSY,
  output logic                DONE,
  output logic                PASS,
  output logic [BV_SUM_W-1:0] SUM
);

  bv_state_t             state, state_nxt;
  logic [ADDR_W-1:0]     remaining;
  logic [BV_SUM_W-1:0]   expected_q;
  logic [READ_LAT-1:0]   vld;
  logic [READ_LAT:0]     vld_shift;
  logic                  start_go;
  logic                  issue_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= BV_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // issue_nxt is the decision to present an address during the coming cycle
  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    issue_nxt = 1'b0;
    case (state)
      BV_IDLE: begin
        if (START) begin
          start_go = 1'b1;
          if (LENGTH == '0) begin
            state_nxt = BV_FINISH;
          end else begin
            state_nxt = BV_RUN;
            issue_nxt = 1'b1;
          end
        end
      end
      BV_RUN: begin
        if (remaining == '0) begin
          state_nxt = BV_DRAIN;
        end else begin
          issue_nxt = 1'b1;
        end
      end
      BV_DRAIN: begin
        if (vld == '0) begin
          state_nxt = BV_FINISH;
        end
      end
      BV_FINISH: begin
        state_nxt = BV_IDLE;
      end
      default: begin
        state_nxt = BV_IDLE;
      end
    endcase
  end

  // Shifting in at issue time makes the top bit line up with the DATA sample edge
  assign vld_shift = {vld, issue_nxt};

  always_ff @(posedge CLK) begin
    if (RST) begin
      ADDR       <= '0;
      N_OE       <= 1'b1;
      remaining  <= '0;
      expected_q <= '0;
      vld        <= '0;
      PASS       <= 1'b0;
    end else begin
      N_OE <= ~issue_nxt;
      vld  <= vld_shift[READ_LAT-1:0];
      if (issue_nxt) begin
        ADDR <= (state == BV_IDLE) ? BASE : ADDR + ADDR_W'(1);
      end
      if (start_go) begin
        remaining  <= LENGTH - ADDR_W'(1);
        expected_q <= EXPECTED;
        PASS       <= (LENGTH == '0) && (EXPECTED == '0);
      end else begin
        if (state == BV_RUN && issue_nxt) begin
          remaining <= remaining - ADDR_W'(1);
        end
        if (state == BV_DRAIN && vld == '0) begin
          PASS <= (SUM == expected_q);
        end
      end
    end
  end

  checksum16 u_checksum (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (start_go),
    .EN   (vld[READ_LAT-1]),
    .DATA (DATA),
    .SUM  (SUM)
  );

  assign BUSY = (state != BV_IDLE);
  assign DONE = (state == BV_FINISH);

endmodule

// File: tb/tb_boot_verifier.sv
// tb/tb_boot_verifier.sv - bench for boot_verifier at READ_LAT 1 and 3 against a cycle-indexed run model
module tb_boot_verifier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [16:0] base = '0;
  logic [16:0] length = '0;
  logic [15:0] expected = '0;

  wire [16:0] addr_w [2];
  wire        noe_w  [2];
  wire        busy_w [2];
  wire        done_w [2];
  wire        pass_w [2];
  wire [15:0] sum_w  [2];
  wire [7:0]  data_w [2];

  logic [16:0] p1 = '0;
  logic [16:0] p2 = '0;
  logic [7:0]  mem [0:131071];

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;
  int ne = 0;

  bit          act   [2];
  int          t0    [2];
  logic [16:0] mbase [2];
  logic [16:0] mlen  [2];
  logic [15:0] mexp  [2];
  logic [16:0] haddr [2];
  logic [15:0] hsum  [2];
  logic        hpass [2];

  always #5 clk = ~clk;

  boot_verifier #(.ADDR_W(17), .READ_LAT(1)) dut0 (
    .CLK(clk), .RST(rst), .START(start), .BASE(base), .LENGTH(length), .EXPECTED(expected),
    .ADDR(addr_w[0]), .N_OE(noe_w[0]), .DATA(data_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0]),
    .PASS(pass_w[0]), .SUM(sum_w[0])
  );

  boot_verifier #(.ADDR_W(17), .READ_LAT(3)) dut1 (
    .CLK(clk), .RST(rst), .START(start), .BASE(base), .LENGTH(length), .EXPECTED(expected),
    .ADDR(addr_w[1]), .N_OE(noe_w[1]), .DATA(data_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1]),
    .PASS(pass_w[1]), .SUM(sum_w[1])
  );

  // SRAM models: combinational for one cycle of latency, two-stage address pipe for three
  assign data_w[0] = mem[addr_w[0]];
  always @(posedge clk) begin
    p1 <= addr_w[1];
    p2 <= p1;
  end
  assign data_w[1] = mem[p2];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", nm, ne, got, want);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int dur(input int i);
    int n;
    n = int'(mlen[i]);
    return (n == 0) ? 1 : n + lat_of(i) + 1;
  endfunction

  // Expected outputs c cycles after the accepted START edge
  function automatic void model_at(input int i, input int c, output logic [16:0] a, output logic noe,
                                   output logic bsy, output logic dn, output logic ps, output logic [15:0] s);
    int n, d, cnt;
    n   = int'(mlen[i]);
    d   = dur(i);
    bsy = (c <= d);
    dn  = (c == d);
    noe = !(c >= 1 && c <= n);
    a   = (n > 0) ? mbase[i] + 17'(((c < n) ? c : n) - 1) : haddr[i];
    cnt = c - lat_of(i);
    if (cnt < 0) cnt = 0;
    if (cnt > n) cnt = n;
    s = 16'h0000;
    for (int k = 0; k < cnt; k++) s = s + {8'h00, mem[mbase[i] + 17'(k)]};
    ps = (c >= d) && (s == mexp[i]);
  endfunction

  logic [16:0] ma;
  logic        mnoe, mbsy, mdone, mpass, mb_busy;
  logic [15:0] ms;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i]   = 1'b0;
        haddr[i] = '0;
        hsum[i]  = '0;
        hpass[i] = 1'b0;
      end else begin
        mb_busy = act[i] && (ne - t0[i] <= dur(i));
        if (act[i] && (ne - t0[i] >= dur(i))) begin
          model_at(i, dur(i), ma, mnoe, mbsy, mdone, mpass, ms);
          haddr[i] = ma;
          hsum[i]  = ms;
          hpass[i] = mpass;
          act[i]   = 1'b0;
        end
        if (start && !mb_busy) begin
          act[i]   = 1'b1;
          t0[i]    = ne;
          mbase[i] = base;
          mlen[i]  = length;
          mexp[i]  = expected;
        end
      end
    end
    ne++;
  end

  logic [16:0] ca;
  logic        cnoe, cbsy, cdone, cpass;
  logic [15:0] cs;

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        if (act[i]) begin
          model_at(i, ne - t0[i], ca, cnoe, cbsy, cdone, cpass, cs);
        end else begin
          ca = haddr[i]; cnoe = 1'b1; cbsy = 1'b0; cdone = 1'b0; cpass = hpass[i]; cs = hsum[i];
        end
        check($sformatf("d%0d addr", i), 32'(addr_w[i]), 32'(ca));
        check($sformatf("d%0d n_oe", i), 32'(noe_w[i]), 32'(cnoe));
        check($sformatf("d%0d busy", i), 32'(busy_w[i]), 32'(cbsy));
        check($sformatf("d%0d done", i), 32'(done_w[i]), 32'(cdone));
        check($sformatf("d%0d pass", i), 32'(pass_w[i]), 32'(cpass));
        check($sformatf("d%0d sum", i), 32'(sum_w[i]), 32'(cs));
      end
    end
  end

  // Returns in cycle 1 (negedge + 1) with the latched inputs already scrambled
  task automatic start_run(input logic [16:0] b, input logic [16:0] l, input logic [15:0] e);
    @(negedge clk); #1;
    start = 1'b1; base = b; length = l; expected = e;
    @(negedge clk); #1;
    start = 1'b0; base = 17'h0BEEF; length = 17'h00005; expected = 16'h1234;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((act[0] || act[1]) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check({nm, " idle0"}, 32'(busy_w[0]), 32'd0);
    check({nm, " idle1"}, 32'(busy_w[1]), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 131072; a++) mem[a] = 8'(a ^ (a >> 8)) ^ 8'h5A;
    mem[17'h00010] = 8'h01; mem[17'h00011] = 8'h02; mem[17'h00012] = 8'h03; mem[17'h00013] = 8'h04;
    mem[17'h1FFFE] = 8'h11; mem[17'h1FFFF] = 8'h22; mem[17'h00000] = 8'h33; mem[17'h00001] = 8'h44;
    for (int k = 0; k < 300; k++) mem[17'h01000 + 17'(k)] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; t0[i] = 0; mbase[i] = '0; mlen[i] = '0; mexp[i] = '0;
      haddr[i] = '0; hsum[i] = '0; hpass[i] = 1'b0;
    end

    repeat (2) @(negedge clk);
    checking = 1'b1;
    check("rst addr", 32'(addr_w[0]), 32'd0);
    check("rst n_oe", 32'(noe_w[0]), 32'd1);
    check("rst busy", 32'(busy_w[0]), 32'd0);
    check("rst done", 32'(done_w[0]), 32'd0);
    check("rst pass", 32'(pass_w[0]), 32'd0);
    check("rst sum", 32'(sum_w[0]), 32'd0);
    #1 rst = 1'b0;

    start_run(17'h00010, 17'd4, 16'h000A);
    check("t1 addr c1", 32'(addr_w[0]), 32'h10);
    check("t1 n_oe c1", 32'(noe_w[0]), 32'd0);
    repeat (3) @(negedge clk);
    check("t1 addr c4", 32'(addr_w[0]), 32'h13);
    repeat (2) @(negedge clk);
    check("t1 done c6", 32'(done_w[0]), 32'd1);
    check("t1 sum c6", 32'(sum_w[0]), 32'h000A);
    check("t1 pass c6", 32'(pass_w[0]), 32'd1);
    wait_idle("t1");

    start_run(17'h00010, 17'd4, 16'h000B);
    repeat (5) @(negedge clk);
    check("t2 done c6", 32'(done_w[0]), 32'd1);
    check("t2 pass c6", 32'(pass_w[0]), 32'd0);
    check("t2 sum c6", 32'(sum_w[0]), 32'h000A);
    wait_idle("t2");

    start_run(17'h00020, 17'd0, 16'h0000);
    check("t3 done c1", 32'(done_w[0]), 32'd1);
    check("t3 pass c1", 32'(pass_w[0]), 32'd1);
    wait_idle("t3");
    start_run(17'h00020, 17'd0, 16'h0001);
    check("t3b pass c1", 32'(pass_w[1]), 32'd0);
    wait_idle("t3b");

    start_run(17'h1FFFE, 17'd4, 16'h00AA);
    @(negedge clk);
    check("t4 addr c2", 32'(addr_w[0]), 32'h1FFFF);
    @(negedge clk);
    check("t4 addr c3", 32'(addr_w[0]), 32'h00000);
    wait_idle("t4");

    start_run(17'h01000, 17'd300, 16'h2AD4);
    repeat (303) @(negedge clk);
    check("t5 done l3 c304", 32'(done_w[1]), 32'd1);
    check("t5 sum l3", 32'(sum_w[1]), 32'h2AD4);
    check("t5 pass l3", 32'(pass_w[1]), 32'd1);
    wait_idle("t5");

    start_run(17'h00010, 17'd8, 16'h0000);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6 busy c4", 32'(busy_w[0]), 32'd0);
    check("t6 n_oe c4", 32'(noe_w[0]), 32'd1);
    check("t6 sum c4", 32'(sum_w[0]), 32'd0);
    check("t6 busy l3 c4", 32'(busy_w[1]), 32'd0);
    #1 rst = 1'b0;
    repeat (15) @(negedge clk);

    start_run(17'h00010, 17'd4, 16'h000A);
    @(negedge clk); #1;
    start = 1'b1; base = 17'h01000; length = 17'd300; expected = 16'h0000;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t7 done c6", 32'(done_w[0]), 32'd1);
    check("t7 pass c6", 32'(pass_w[0]), 32'd1);
    check("t7 sum c6", 32'(sum_w[0]), 32'h000A);
    wait_idle("t7");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
